// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port controller: geometry,
// the NOP word returned on bad fetches, FSM encoding and the range check.
package imem_pkg;

  localparam int unsigned DEPTH = 8192;
  localparam int unsigned AW    = $clog2(DEPTH);

  // sll $0,$0,0 -- what the core sees for an out-of-range fetch
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Word index addr[31:2] must be below depth; byte-offset bits are ignored.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return ({2'b00, addr[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/imem_rr_arbiter.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is the fetch port, req[1]/gnt[1]
// the loader. The priority bit only moves when both ports contend.
module imem_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // rr_q=0 favours fetch, rr_q=1 favours the loader on the next contention
  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    rr_d  = rr_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = rr_q ? 2'b10 : 2'b01;
        rr_d  = ~rr_q;
      end else begin
        gnt_o = req_i;
      end
    end
    if (clr_i) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/imem_port_ctrl.sv
// Shares a single-port sync-read instruction memory between CPU fetch and the
// program loader: loader-only BOOT phase, then round-robin RUN phase.
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = imem_pkg::DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req_i,
  input  logic [31:0]   fetch_pc_i,
  output logic          fetch_gnt_o,
  output logic          fetch_stall_o,
  output logic          fetch_valid_o,
  output logic [31:0]   fetch_instr_o,
  output logic          fetch_err_o,
  input  logic          load_req_i,
  input  logic [31:0]   load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          load_gnt_o,
  output logic          load_err_o,
  output logic          booting_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  state_e     state_q, state_d;
  logic [1:0] arb_gnt;
  logic       arb_en, arb_clr;
  logic       f_ok, l_ok;
  logic       fvld_q, ferr_q, lerr_q;

  assign f_ok = in_range(fetch_pc_i, DEPTH);
  assign l_ok = in_range(load_addr_i, DEPTH);

  // Grants are combinational, so reset has to gate them directly
  assign arb_en = rst_n & (state_q == RUN);

  imem_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .clr_i (arb_clr),
    .req_i ({load_req_i, fetch_req_i}),
    .gnt_o (arb_gnt)
  );

  assign fetch_gnt_o   = arb_gnt[0];
  assign load_gnt_o    = (state_q == BOOT) ? (rst_n & load_req_i) : arb_gnt[1];
  assign fetch_stall_o = fetch_req_i & ~fetch_gnt_o;
  assign booting_o     = (state_q == BOOT);

  always_comb begin
    state_d = state_q;
    arb_clr = 1'b0;
    case (state_q)
      BOOT: if (load_gnt_o && load_last_i) begin
        state_d = RUN;
        arb_clr = 1'b1;
      end
      RUN:  state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Out-of-range requests are granted but never reach the memory
  assign mem_we_o    = load_gnt_o & l_ok;
  assign mem_en_o    = mem_we_o | (fetch_gnt_o & f_ok);
  assign mem_addr_o  = load_gnt_o ? load_addr_i[AW+1:2] : fetch_pc_i[AW+1:2];
  assign mem_wdata_o = load_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      fvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fvld_q  <= fetch_gnt_o;
      ferr_q  <= fetch_gnt_o & ~f_ok;
      lerr_q  <= load_gnt_o & ~l_ok;
    end
  end

  assign fetch_valid_o = fvld_q;
  assign fetch_err_o   = ferr_q;
  assign fetch_instr_o = (fvld_q && !ferr_q) ? mem_rdata_i : NOP;
  assign load_err_o    = lerr_q;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Randomized plus directed bench for imem_port_ctrl against a transaction-level
// model of the boot/round-robin rules and a reference copy of the memory.
module tb_imem_port_ctrl;
  localparam int D  = 8192;
  localparam int AW = 13;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          fetch_req = 1'b0, load_req = 1'b0, load_last = 1'b0;
  logic [31:0]   fetch_pc = '0, load_addr = '0, load_data = '0;
  logic          fetch_gnt, fetch_stall, fetch_valid, fetch_err;
  logic [31:0]   fetch_instr;
  logic          load_gnt, load_err, booting;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  imem_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc), .fetch_gnt_o(fetch_gnt),
    .fetch_stall_o(fetch_stall), .fetch_valid_o(fetch_valid),
    .fetch_instr_o(fetch_instr), .fetch_err_o(fetch_err),
    .load_req_i(load_req), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_last_i(load_last), .load_gnt_o(load_gnt), .load_err_o(load_err),
    .booting_o(booting), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory the DUT drives
  logic [31:0] env_mem [D];
  always @(posedge clk) begin
    if (mem_en && mem_we)  env_mem[mem_addr] <= mem_wdata;
    else if (mem_en)       mem_rdata <= env_mem[mem_addr];
  end

  // Reference model state
  logic [31:0] ref_mem [D];
  bit          m_run, m_fav_load;
  bit          e_fv, e_ferr, e_lerr;
  logic [31:0] e_instr;
  bit          last_wr;
  int          last_wr_idx;
  logic [31:0] last_wr_old;
  int          n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit fr, input logic [31:0] pc, input bit lr,
                     input logic [31:0] la, input logic [31:0] ld, input bit ll);
    longint unsigned fi, li;
    bit fok, lok, gf, gl, en;
    @(negedge clk);
    fetch_req = fr; fetch_pc = pc; load_req = lr;
    load_addr = la; load_data = ld; load_last = ll;
    #1;
    fi = longint'(pc) >> 2; li = longint'(la) >> 2;
    fok = fi < D; lok = li < D;
    if (!m_run) begin gf = 0; gl = lr; end
    else if (fr && lr) begin gf = !m_fav_load; gl = m_fav_load; end
    else begin gf = fr; gl = lr; end
    en = (gf && fok) || (gl && lok);
    check("booting", 32'(booting), 32'(!m_run));
    check("fvalid",  32'(fetch_valid), 32'(e_fv));
    check("finstr",  fetch_instr, e_instr);
    check("ferr",    32'(fetch_err), 32'(e_ferr));
    check("lerr",    32'(load_err), 32'(e_lerr));
    check("fgnt",    32'(fetch_gnt), 32'(gf));
    check("lgnt",    32'(load_gnt), 32'(gl));
    check("stall",   32'(fetch_stall), 32'(fr && !gf));
    check("mem_en",  32'(mem_en), 32'(en));
    if (en) begin
      check("mem_we",   32'(mem_we), 32'(gl && lok));
      check("mem_addr", 32'(mem_addr), gl ? 32'(li) : 32'(fi));
      if (gl) check("mem_wdata", mem_wdata, ld);
    end
    // model advance for the coming edge
    e_fv    = gf;
    e_ferr  = gf && !fok;
    e_instr = (gf && fok) ? ref_mem[fi] : 32'h0;
    e_lerr  = gl && !lok;
    last_wr = gl && lok;
    if (last_wr) begin
      last_wr_idx = int'(li); last_wr_old = ref_mem[li]; ref_mem[li] = ld;
    end
    if (!m_run) begin
      if (gl && ll) begin m_run = 1; m_fav_load = 0; end
    end else if (fr && lr) m_fav_load = gf;
  endtask

  // Called mid-cycle (before the next edge), so the last modelled write never lands
  task automatic rst_pulse;
    rst_n = 1'b0;
    #1;
    check("rst_fgnt",  32'(fetch_gnt), 32'h0);
    check("rst_lgnt",  32'(load_gnt), 32'h0);
    check("rst_memen", 32'(mem_en), 32'h0);
    check("rst_boot",  32'(booting), 32'h1);
    check("rst_fvld",  32'(fetch_valid), 32'h0);
    check("rst_lerr",  32'(load_err), 32'h0);
    if (last_wr) ref_mem[last_wr_idx] = last_wr_old;
    last_wr = 0; m_run = 0; m_fav_load = 0;
    e_fv = 0; e_ferr = 0; e_lerr = 0; e_instr = 32'h0;
    @(posedge clk); #1;
    check("rst_fvld2",  32'(fetch_valid), 32'h0);
    check("rst_finstr", fetch_instr, 32'h0);
    @(negedge clk);
    fetch_req = 0; load_req = 0; load_last = 0;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom % 10)
      0:       return 32'h0000_7FFC;
      1:       return 32'h0000_8000;
      2:       return $urandom;
      default: return (32'($urandom_range(0, 31)) << 2) | 32'($urandom % 4);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < D; i++) begin env_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst_pulse();

    // boot load, last on third word, fetch queued behind it
    cyc(1, 32'h4, 1, 32'h0, 32'h2008_01F4, 0);
    cyc(1, 32'h4, 1, 32'h4, 32'h2010_0007, 0);
    cyc(1, 32'h4, 1, 32'h8, 32'h2011_0000, 1);
    cyc(1, 32'h4, 0, 32'h0, 32'h0, 0);
    cyc(0, 32'h0, 0, 32'h0, 32'h0, 0);

    // fetch held during BOOT never granted
    rst_pulse();
    repeat (5) cyc(1, 32'h8, 0, 32'h0, 32'h0, 0);
    cyc(0, 32'h0, 1, 32'h100, 32'h1234_5678, 1);

    // contention: F, L, F, L
    for (int k = 0; k < 4; k++)
      cyc(1, 32'(k) << 2, 1, 32'h200 + (32'(k) << 2), 32'hA000_0000 + 32'(k), 0);

    // range boundary
    cyc(1, 32'h7FFC, 0, 32'h0, 32'h0, 0);
    cyc(1, 32'h8000, 0, 32'h0, 32'h0, 0);
    cyc(0, 32'h0, 1, 32'h8000, 32'hBAD0_BAD0, 0);
    cyc(1, 32'h7FFC, 0, 32'h0, 32'h0, 0);

    // write then read same word
    cyc(0, 32'h0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    cyc(1, 32'h10, 0, 32'h0, 32'h0, 0);
    cyc(0, 32'h0, 0, 32'h0, 32'h0, 0);

    // reset while the fetch result is in flight
    cyc(1, 32'h10, 0, 32'h0, 32'h0, 0);
    rst_pulse();
    cyc(1, 32'h10, 0, 32'h0, 32'h0, 0);
    cyc(1, 32'h10, 1, 32'h14, 32'hCAFE_F00D, 1);

    // random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom % 3 != 0, rnd_addr(), $urandom % 2 == 0, rnd_addr(),
          $urandom, $urandom % 12 == 0);
      if ($urandom % 150 == 0) rst_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imem_port_ctrl.md
# imem_port_ctrl

Controller for the single-port, synchronous-read instruction memory of the single-cycle MIPS core. It shares the memory between the CPU fetch port (reads) and a program-loader port (writes). It sequences a boot phase in which only the loader may write, then runs two-way round-robin arbitration. It also range-checks addresses so out-of-range fetches return a NOP instead of touching memory.

## Interface
- DEPTH, 8192, memory depth in 32-bit words
- AW, 13, word-index width, $clog2(DEPTH)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- fetch_req  in  1  CPU requests an instruction
- fetch_pc  in  32  byte address; bits [1:0] ignored
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_stall  out  1  fetch_req & ~fetch_gnt
- fetch_valid  out  1  instruction/result present (registered)
- fetch_instr  out  32  instruction; 0 when fetch_valid=0 or on error
- fetch_err  out  1  qualifies fetch_valid; address was out of range
- load_req  in  1  loader requests a word write
- load_addr  in  32  byte address; bits [1:0] ignored
- load_data  in  32  write data
- load_last  in  1  final boot word; sampled only on a granted load
- load_gnt  out  1  write accepted this cycle (combinational)
- load_err  out  1  one-cycle pulse: granted write was out of range and dropped
- booting  out  1  1 while in BOOT
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  AW  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en & ~mem_we

## Operation
- States: BOOT (reset state) and RUN.
- BOOT:
  - fetch_gnt=0.
  - load_gnt=load_req.
  - A granted load with load_last=1 moves the FSM to RUN at the next edge.
- RUN, arbitration per cycle:
  - A single requester is always granted.
  - If both request, grant the requester that did not win the previous contention.
  - The round-robin bit is updated only on contention and is cleared to favour fetch on BOOT→RUN.
- Range check: word index = addr[31:2]. In range iff the index is < DEPTH, so all DEPTH words are addressable, including index DEPTH-1.
- Granted in-range fetch:
  - Drives mem_en=1, mem_we=0, mem_addr=index.
  - Next cycle: fetch_valid=1, fetch_instr=mem_rdata, fetch_err=0.
- Granted out-of-range fetch:
  - mem_en=0.
  - Next cycle: fetch_valid=1, fetch_instr=32'h0000_0000 (sll nop), fetch_err=1.
- Granted in-range load: mem_en=1, mem_we=1, mem_addr=index, mem_wdata=load_data.
- Granted out-of-range load: mem_en=0; load_err pulses next cycle. load_last is still honoured.
- At most one memory access per cycle. No grant is given without a request.
- Memory strobes are 0 when no grant is given.

## Timing
- Reset (reset=0), asynchronous:
  - state=BOOT, rr bit=0.
  - fetch_valid=0, fetch_err=0, fetch_instr=0, load_err=0, booting=1.
  - Grants and memory strobes are 0 while reset=0.
- Fetch latency: grant in cycle N → fetch_valid in N+1. Throughput is 1 fetch/cycle when uncontended.
- fetch_valid is a one-cycle pulse per grant. fetch_instr is not held afterwards.
- Write then read of the same word in consecutive cycles returns the new data (memory is write-before-read across cycles).
- Reset asserted mid-operation:
  - In-flight read is discarded; fetch_valid stays 0.
  - FSM returns to BOOT; memory contents are untouched.
- load_last on the same cycle as a BOOT→RUN-causing grant: fetch is not granted until the following cycle.
- Requests in the same cycle as reset deassertion are ignored until the first clock edge.

## Structure
- Shared package imem_pkg:
  - DEPTH and AW defaults.
  - NOP constant 32'h0000_0000.
  - State encoding BOOT=1'b0, RUN=1'b1.
- Sub-module imem_rr_arbiter:
  - Two-way round-robin arbiter with an enable input.
  - Inputs: req[1:0], en, clock, reset. Output: gnt[1:0].
  - Holds the rr bit internally; takes a clear input for BOOT→RUN.
- Top level holds the FSM, range checks, memory muxing, and result registers.

## Test plan
- Boot load: reset pulse; loads to 0x0, 0x4, 0x8 (data 200801F4, 20100007, 20110000), last on third. Then fetch pc=0x4 → booting falls after third grant; fetch_valid next cycle with fetch_instr=20100007, fetch_err=0.
- Fetch during BOOT: fetch_req=1 for 5 cycles with no loads → fetch_gnt=0 and fetch_stall=1 throughout; mem_en=0.
- Contention: in RUN, both requesting for 4 cycles → grants F, L, F, L; exactly one mem_en per cycle; fetched data is correct.
- Range boundary:
  - pc=0x7FFC (word 8191) → mem_addr=8191, err=0.
  - pc=0x8000 → mem_en=0, next cycle valid=1, instr=0, err=1.
  - load_addr=0x8000 → load_err pulse, no write.
- Reset mid-fetch: assert reset the cycle after a fetch grant → fetch_valid never rises; after release, booting=1 and fetch_gnt=0.
- Write-then-read: in RUN, load 0x10=DEADBEEF, fetch 0x10 next cycle → fetch_instr=DEADBEEF.
